led_matrix_driver: RTL and testbench
====================================

// Module: led_matrix_driver
// PURPOSE
//   Top-level 8x8 monochrome LED matrix driver.
//   - An SPI slave (mode 0, MSB first) loads row bytes into a 64-bit frame buffer.
//   - The block time-multiplexes the buffer onto the matrix:
//     one-hot row drive on uio_out, column data on uo_out.
// PARAMETERS
//   SCAN_LOG2   8   clocks per row period = 2**SCAN_LOG2 (row advances every 256 clk)
//   BLANK_CYC   4   clocks at start of each row period with uo_out forced 0 (anti-ghost)
// PORTS
//   clk      in   1  system clock (single clock domain)
//   rst_n    in   1  asynchronous active-low reset
//   ena      in   1  design-enable; ignored
//   ui_in    in   8  [0]=SCK, [1]=MOSI, [2]=CS_N (active low), [3]=unused;
//                    [7:4]=brightness (used only with LED_MATRIX_BRIGHTNESS_EN)
//   uo_out   out  8  column data of current row, active high, bit i = column i
//   uio_in   in   8  unused
//   uio_out  out  8  row select, one-hot active high, bit r = row r
//   uio_oe   out  8  constant 8'hFF
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - frame buffer all 0; row counter 0; period counter 0; SPI state idle.
//   - uo_out=8'h00, uio_out=8'h01; uio_oe is always 8'hFF.
//   SPI input:
//   - SCK, MOSI and CS_N each pass through a 2-FF synchronizer.
//   - SCK rising edge is detected on synchronized samples (prev 0, now 1).
//   - clk must be >= 4x the SCK frequency.
//   - While CS_N=0, each SCK rising edge shifts MOSI into the shift register
//     MSB-first; 8 edges complete a byte.
//   - Byte 0 of a transaction: address byte; bits[2:0] load the row pointer,
//     bits[7:3] ignored.
//   - Byte 1..n: data bytes.
//     - buffer[ptr] <= byte, one clk after the 8th edge is detected.
//     - ptr <= ptr+1, wrapping 7 -> 0; unlimited bytes per transaction.
//   - CS_N high:
//     - aborts the transaction: bit counter and byte index cleared;
//       a partial byte is discarded (no write).
//     - SCK edges are ignored.
//   Scan:
//   - Free-running period counter, width SCAN_LOG2.
//   - On wrap: row <= row+1 (mod 8); uio_out <= 1<<row_next.
//   - uo_out <= buffer[row], except 8'h00 while the period counter < BLANK_CYC.
//   - All outputs are registered.
//   - A buffer write is visible the next time that row's period passes BLANK_CYC;
//     a write to the currently displayed row takes effect on the next clk after it.
//   Simultaneous SPI write and scan read of the same row: the scan sees the new data
//   one clk later; no tearing beyond one clk.
//   Reset mid-transaction: buffer cleared, partial data lost; scan restarts at row 0.
// CONFIGURATION
//   LED_MATRIX_BRIGHTNESS_EN defined:
//   - b = ui_in[7:4], synchronized.
//   - Columns are additionally forced 0 when period_cnt[SCAN_LOG2-1 -: 4] > b.
//   - On-time = (b+1)/16 of the row period, minus blanking.
//   - b=15 gives the same output as the macro-undefined build.
//   Undefined: ui_in[7:4] ignored; full on-time apart from BLANK_CYC.
// TESTING
//   1. Reset: rst_n low -> uo_out=00, uio_out=01, uio_oe=FF.
//      After release, uio_out=02 after 256 clk and 80 after 7*256 clk.
//   2. CS_N low, send 03,A5, CS_N high -> while uio_out=08 and count>=4, uo_out=A5;
//      all other rows show 00.
//   3. Burst 06,11,22,33 -> rows 6,7,0 = 11,22,33 (pointer wrap).
//   4. Send 00 then 5 bits of FF, raise CS_N -> row0 unchanged (00).
//      Next transaction 00,3C -> row0 = 3C.
//   5. Pulse rst_n low mid-byte -> all rows 00, scan restarts at row 0.
//   6. (_EN) buffer row0=FF, ui_in[7:4]=3 -> uo_out=FF only while period_cnt in [4,63],
//      else 00.

Source files
------------

// File: rtl/led_matrix_driver.sv
// led_matrix_driver: SPI-loaded 8x8 frame buffer, row-scanned onto uio_out (rows) / uo_out (columns).
// All outputs registered; define LED_MATRIX_BRIGHTNESS_EN to add PWM dimming from ui_in[7:4].
module led_matrix_driver #(
   parameter int SCAN_LOG2 = 8,
   parameter int BLANK_CYC = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } spi_state_t;

   localparam logic [SCAN_LOG2-1:0] LP_BLANK = SCAN_LOG2'(BLANK_CYC);

   logic [1:0]       r_sck_sync;
   logic [1:0]       r_mosi_sync;
   logic [1:0]       r_csn_sync;
   logic             r_sck_prev;
   logic             w_sck_rise;
   logic             w_cs_act;

   spi_state_t       r_state;
   spi_state_t       w_state_nxt;
   logic             w_shift_en;
   logic             w_byte_end;
   logic [2:0]       r_bit_cnt;
   logic [6:0]       r_shift;
   logic             r_byte_vld;
   logic             r_byte_is_addr;
   logic [7:0]       r_byte_dat;
   logic [2:0]       r_ptr;
   logic [7:0][7:0]  r_fb;

   logic [SCAN_LOG2-1:0] r_period_cnt;
   logic [SCAN_LOG2-1:0] w_cnt_nxt;
   logic                 w_wrap;
   logic [2:0]           r_row;
   logic [2:0]           w_row_nxt;
   logic                 w_blank;
   logic                 w_dim;
   logic [7:0]           w_col_nxt;
   logic [7:0]           r_uo_out;
   logic [7:0]           r_uio_out;
   logic                 w_unused;

   // CS_N resets to inactive so no transaction can appear out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sck_sync  <= 2'b00;
         r_mosi_sync <= 2'b00;
         r_csn_sync  <= 2'b11;
         r_sck_prev  <= 1'b0;
      end else begin
         r_sck_sync  <= {r_sck_sync[0], ui_in[0]};
         r_mosi_sync <= {r_mosi_sync[0], ui_in[1]};
         r_csn_sync  <= {r_csn_sync[0], ui_in[2]};
         r_sck_prev  <= r_sck_sync[1];
      end
   end

   assign w_sck_rise = r_sck_sync[1] & ~r_sck_prev;
   assign w_cs_act   = ~r_csn_sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_byte_end  = 1'b0;
      if (w_cs_act) begin
         w_shift_en = w_sck_rise;
         w_byte_end = w_sck_rise && (r_bit_cnt == 3'd7);
      end
      case (r_state)
         ST_IDLE: if (w_cs_act) w_state_nxt = w_byte_end ? ST_DATA : ST_ADDR;
         ST_ADDR: begin
            if (!w_cs_act)      w_state_nxt = ST_IDLE;
            else if (w_byte_end) w_state_nxt = ST_DATA;
         end
         ST_DATA: if (!w_cs_act) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Only the 7 newest bits are kept; the 8th is merged directly into the byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt      <= 3'd0;
         r_shift        <= 7'd0;
         r_byte_vld     <= 1'b0;
         r_byte_is_addr <= 1'b0;
         r_byte_dat     <= 8'd0;
      end else begin
         if (!w_cs_act) begin
            r_bit_cnt <= 3'd0;
         end else if (w_shift_en) begin
            r_shift   <= {r_shift[5:0], r_mosi_sync[1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         r_byte_vld <= w_byte_end;
         if (w_byte_end) begin
            r_byte_dat     <= {r_shift, r_mosi_sync[1]};
            r_byte_is_addr <= (r_state != ST_DATA);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 3'd0;
         r_fb  <= '0;
      end else if (r_byte_vld) begin
         if (r_byte_is_addr) begin
            r_ptr <= r_byte_dat[2:0];
         end else begin
            r_fb[r_ptr] <= r_byte_dat;
            r_ptr       <= r_ptr + 3'd1;
         end
      end
   end

   assign w_cnt_nxt = r_period_cnt + 1'b1;
   assign w_wrap    = &r_period_cnt;
   assign w_row_nxt = r_row + {2'b00, w_wrap};
   assign w_blank   = (w_cnt_nxt < LP_BLANK);

`ifdef LED_MATRIX_BRIGHTNESS_EN
   logic [1:0][3:0] r_bri_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_bri_sync <= '0;
      else        r_bri_sync <= {r_bri_sync[0], ui_in[7:4]};
   end

   assign w_dim    = (w_cnt_nxt[SCAN_LOG2-1 -: 4] > r_bri_sync[1]);
   assign w_unused = ^{ena, uio_in, ui_in[3]};
`else
   assign w_dim    = 1'b0;
   assign w_unused = ^{ena, uio_in, ui_in[7:3]};
`endif

   // Column data is computed for the next counter/row so uo_out lines up with uio_out.
   assign w_col_nxt = (w_blank | w_dim) ? 8'h00 : r_fb[w_row_nxt];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_period_cnt <= '0;
         r_row        <= 3'd0;
         r_uo_out     <= 8'h00;
         r_uio_out    <= 8'h01;
      end else begin
         r_period_cnt <= w_cnt_nxt;
         r_row        <= w_row_nxt;
         r_uo_out     <= w_col_nxt;
         r_uio_out    <= 8'h01 << w_row_nxt;
      end
   end

   assign uo_out  = r_uo_out;
   assign uio_out = r_uio_out;
   assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_led_matrix_driver.sv
// Directed bench for led_matrix_driver: reset, SPI writes, pointer wrap, abort, mid-byte reset, dimming.
module tb_led_matrix_driver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   logic       sck;
   logic       mosi;
   logic       csn;
   logic [3:0] bri;

   int total = 0;
   int bad   = 0;

   assign ui_in = {bri, 1'b0, csn, mosi, sck};

   always #5 clk = ~clk;

   led_matrix_driver dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bit(input logic b);
      mosi = b;
      clk_wait(4);
      sck = 1'b1;
      clk_wait(4);
      sck = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) spi_bit(v[i]);
   endtask

   task automatic spi_begin();
      csn = 1'b0;
      clk_wait(4);
   endtask

   task automatic spi_end();
      clk_wait(4);
      csn = 1'b1;
      clk_wait(6);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clk_wait(3);
      rst_n = 1'b1;
      clk_wait(1);
   endtask

   // Waits for the start of a fresh period of row r, then checks blanking and the column value.
   task automatic check_row(input int r, input logic [7:0] exp, input string name);
      logic [7:0] tgt;
      int n;
      tgt = 8'h01 << r;
      n = 0;
      while (uio_out == tgt && n < 3000) begin clk_wait(1); n++; end
      while (uio_out != tgt && n < 3000) begin clk_wait(1); n++; end
      if (n >= 3000) begin
         total++; bad++;
         $display("FAIL %s: row %0d never selected, uio_out=%02h", name, r, uio_out);
         return;
      end
      total++;
      if (uo_out !== 8'h00) begin
         bad++;
         $display("FAIL %s blank@0: got %02h want 00", name, uo_out);
      end
      clk_wait(3);
      total++;
      if (uo_out !== 8'h00) begin
         bad++;
         $display("FAIL %s blank@3: got %02h want 00", name, uo_out);
      end
      clk_wait(1);
      total++;
      if (uo_out !== exp) begin
         bad++;
         $display("FAIL %s col@4: got %02h want %02h", name, uo_out, exp);
      end
      clk_wait(251);
      total++;
      if (uo_out !== exp || uio_out !== tgt) begin
         bad++;
         $display("FAIL %s col@255: got %02h/%02h want %02h/%02h", name, uo_out, uio_out, exp, tgt);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clk_wait(3);
      total++;
      if (uo_out !== 8'h00) begin bad++; $display("FAIL reset_uo: got %02h want 00", uo_out); end
      total++;
      if (uio_out !== 8'h01) begin bad++; $display("FAIL reset_uio: got %02h want 01", uio_out); end
      total++;
      if (uio_oe !== 8'hFF) begin bad++; $display("FAIL reset_oe: got %02h want ff", uio_oe); end
      rst_n = 1'b1;
      clk_wait(255);
      total++;
      if (uio_out !== 8'h01) begin bad++; $display("FAIL scan_255: got %02h want 01", uio_out); end
      clk_wait(1);
      total++;
      if (uio_out !== 8'h02) begin bad++; $display("FAIL scan_256: got %02h want 02", uio_out); end
      clk_wait(1535);
      total++;
      if (uio_out !== 8'h40) begin bad++; $display("FAIL scan_1791: got %02h want 40", uio_out); end
      clk_wait(1);
      total++;
      if (uio_out !== 8'h80) begin bad++; $display("FAIL scan_1792: got %02h want 80", uio_out); end
   endtask

   task automatic test_single_write();
      spi_begin();
      spi_byte(8'h03);
      spi_byte(8'hA5);
      spi_end();
      check_row(3, 8'hA5, "row3_a5");
      check_row(2, 8'h00, "row2_zero");
      check_row(4, 8'h00, "row4_zero");
   endtask

   task automatic test_burst_wrap();
      spi_begin();
      spi_byte(8'h06);
      spi_byte(8'h11);
      spi_byte(8'h22);
      spi_byte(8'h33);
      spi_end();
      check_row(6, 8'h11, "burst_row6");
      check_row(7, 8'h22, "burst_row7");
      check_row(0, 8'h33, "burst_row0");
      check_row(3, 8'hA5, "burst_row3_kept");
   endtask

   task automatic test_abort();
      do_reset();
      spi_begin();
      spi_byte(8'h00);
      for (int i = 0; i < 5; i++) spi_bit(1'b1);
      spi_end();
      check_row(0, 8'h00, "abort_row0");
      spi_begin();
      spi_byte(8'h00);
      spi_byte(8'h3C);
      spi_end();
      check_row(0, 8'h3C, "after_abort_row0");
      check_row(1, 8'h00, "after_abort_row1");
   endtask

   task automatic test_reset_mid_byte();
      spi_begin();
      spi_byte(8'h07);
      spi_byte(8'h5A);
      spi_end();
      check_row(7, 8'h5A, "pre_rst_row7");
      spi_begin();
      spi_byte(8'h00);
      for (int i = 0; i < 3; i++) spi_bit(1'b1);
      rst_n = 1'b0;
      clk_wait(2);
      total++;
      if (uio_out !== 8'h01 || uo_out !== 8'h00) begin
         bad++;
         $display("FAIL midrst_out: got %02h/%02h want 01/00", uio_out, uo_out);
      end
      csn = 1'b1;
      sck = 1'b0;
      clk_wait(2);
      rst_n = 1'b1;
      clk_wait(128);
      total++;
      if (uio_out !== 8'h01) begin bad++; $display("FAIL midrst_scan: got %02h want 01", uio_out); end
      check_row(7, 8'h00, "midrst_row7");
      check_row(0, 8'h00, "midrst_row0");
   endtask

`ifdef LED_MATRIX_BRIGHTNESS_EN
   task automatic test_brightness();
      int n;
      bri = 4'd3;
      spi_begin();
      spi_byte(8'h00);
      spi_byte(8'hFF);
      spi_end();
      n = 0;
      while (uio_out == 8'h01 && n < 3000) begin clk_wait(1); n++; end
      while (uio_out != 8'h01 && n < 3000) begin clk_wait(1); n++; end
      if (n >= 3000) begin
         total++; bad++;
         $display("FAIL bri_timeout: uio_out=%02h", uio_out);
      end else begin
         clk_wait(3);
         total++;
         if (uo_out !== 8'h00) begin bad++; $display("FAIL bri@3: got %02h want 00", uo_out); end
         clk_wait(1);
         total++;
         if (uo_out !== 8'hFF) begin bad++; $display("FAIL bri@4: got %02h want ff", uo_out); end
         clk_wait(59);
         total++;
         if (uo_out !== 8'hFF) begin bad++; $display("FAIL bri@63: got %02h want ff", uo_out); end
         clk_wait(1);
         total++;
         if (uo_out !== 8'h00) begin bad++; $display("FAIL bri@64: got %02h want 00", uo_out); end
         clk_wait(191);
         total++;
         if (uo_out !== 8'h00) begin bad++; $display("FAIL bri@255: got %02h want 00", uo_out); end
      end
      bri = 4'hF;
   endtask
`endif

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      uio_in = 8'h00;
      sck    = 1'b0;
      mosi   = 1'b0;
      csn    = 1'b1;
      bri    = 4'hF;
      test_reset();
      test_single_write();
      test_burst_wrap();
      test_abort();
      test_reset_mid_byte();
`ifdef LED_MATRIX_BRIGHTNESS_EN
      test_brightness();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
